// File: rtl/cache_dbg_pkg.sv
// Shared types and default widths for the cache traffic checker.
package cache_dbg_pkg;

  localparam int unsigned ADDR_W_DEF = 27;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ERR_CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {FILL, VERIFY, MIX} phase_t;

endpackage

// File: rtl/cache_dbg_addr_gen.sv
// Stride accumulator: walks BASE, BASE+S, BASE+2S, ... without a multiplier.
module cache_dbg_addr_gen
  import cache_dbg_pkg::*;
#(
  parameter int unsigned        ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  BASE       = '0,
  parameter logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(27'h0214C0C),
  parameter logic [ADDR_W-1:0]  MIX_STRIDE = ADDR_W'(27'h0A0404C)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              step,
  input  logic              sel_mix,
  output logic [ADDR_W-1:0] addr
);

  // Clear has priority over step; the sum wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rstn || clear) addr <= BASE;
    else if (step)      addr <= addr + (sel_mix ? MIX_STRIDE : STRIDE);
  end

endmodule

// File: rtl/cache_traffic_checker.sv
// Self-checking cache traffic generator: FILL writes, VERIFY reads, then
// interleaved write/read-back (MIX), with error and timeout reporting.
module cache_traffic_checker
  import cache_dbg_pkg::*;
#(
  parameter int unsigned        ADDR_W     = ADDR_W_DEF,
  parameter int unsigned        DATA_W     = DATA_W_DEF,
  parameter int unsigned        N_OPS      = 100,
  parameter logic [ADDR_W-1:0]  BASE       = '0,
  parameter logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(27'h0214C0C),
  parameter logic [ADDR_W-1:0]  MIX_STRIDE = ADDR_W'(27'h0A0404C),
  parameter logic [DATA_W-1:0]  SEED       = DATA_W'(1),
  parameter int unsigned        TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 cache2core_wr_fin,
  input  logic                 cache2core_rd_fin,
  input  logic [DATA_W-1:0]    cache2core_rd_data,
  output logic [ADDR_W-1:0]    core2cache_rd_addr,
  output logic [ADDR_W-1:0]    core2cache_wr_addr,
  output logic [DATA_W-1:0]    core2cache_wr_data,
  output logic                 core2cache_rd_en,
  output logic                 core2cache_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 timeout
);

  localparam int unsigned       IDX_W    = 16;
  localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_OPS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t              state;
  phase_t              phase;
  logic [IDX_W-1:0]    idx;
  logic                mix_rd;
  logic [DATA_W-1:0]   dat;
  logic [TO_W-1:0]     to_cnt;
  logic [ADDR_W-1:0]   addr;

  logic                op_wr;
  logic                fin;
  logic                accept;
  logic                last;
  logic                launch;
  logic                addr_clr;
  logic                addr_step;
  logic [DATA_W-1:0]   exp_data;

  // Current op type, fin qualification and accumulator control.
  always_comb begin
    op_wr     = (phase == FILL) || ((phase == MIX) && !mix_rd);
    fin       = op_wr ? cache2core_wr_fin : cache2core_rd_fin;
    // to_cnt is zero only in the en cycle, so a fin there is ignored
    accept    = (state == WAIT) && (to_cnt != '0) && fin;
    last      = (idx == LAST_IDX);
    launch    = start && ((state == IDLE) || (state == DONE));
    exp_data  = (phase == VERIFY) ? dat : ~dat;
    addr_clr  = launch || (accept && last && (phase != MIX));
    addr_step = accept && !last && ((phase != MIX) || mix_rd);
  end

  cache_dbg_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE       (BASE),
    .STRIDE     (STRIDE),
    .MIX_STRIDE (MIX_STRIDE)
  ) u_addr_gen (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (addr_clr),
    .step    (addr_step),
    .sel_mix (phase == MIX),
    .addr    (addr)
  );

  // Control FSM with registered request, status and error outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state              <= IDLE;
      phase              <= FILL;
      idx                <= '0;
      mix_rd             <= 1'b0;
      dat                <= SEED;
      to_cnt             <= '0;
      core2cache_rd_addr <= '0;
      core2cache_wr_addr <= '0;
      core2cache_wr_data <= '0;
      core2cache_rd_en   <= 1'b0;
      core2cache_wr_en   <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_cnt            <= '0;
      first_err_addr     <= '0;
      timeout            <= 1'b0;
    end else begin
      core2cache_rd_en <= 1'b0;
      core2cache_wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= ISSUE;
            busy           <= 1'b1;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            phase          <= FILL;
            idx            <= '0;
            mix_rd         <= 1'b0;
            dat            <= SEED;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          to_cnt <= '0;
          if (op_wr) begin
            core2cache_wr_en   <= 1'b1;
            core2cache_wr_addr <= addr;
            core2cache_wr_data <= (phase == FILL) ? dat : ~dat;
          end else begin
            core2cache_rd_en   <= 1'b1;
            core2cache_rd_addr <= addr;
          end
        end
        WAIT: begin
          if (accept) begin
            if (!op_wr && (cache2core_rd_data != exp_data)) begin
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
              if (err_cnt == '0) first_err_addr <= core2cache_rd_addr;
            end
            state <= ISSUE;
            if (phase == MIX) begin
              if (!mix_rd) begin
                mix_rd <= 1'b1;
              end else if (last) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                mix_rd <= 1'b0;
                idx    <= idx + IDX_W'(1);
                dat    <= dat + DATA_W'(1);
              end
            end else if (last) begin
              idx   <= '0;
              dat   <= SEED;
              phase <= (phase == FILL) ? VERIFY : MIX;
            end else begin
              idx <= idx + IDX_W'(1);
              dat <= dat + DATA_W'(1);
            end
          end else if (to_cnt == TO_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_traffic_checker.sv
// Directed bench for cache_traffic_checker with a fixed-latency (L=3) memory.
module tb_cache_traffic_checker;

  localparam logic [26:0] STR   = 27'h0214C0C;
  localparam logic [26:0] MSTR  = 27'h0A0404C;
  localparam logic [26:0] WBASE = 27'h7FFFFF0;
  localparam logic [26:0] CORR_A = 27'h0429818;  // VERIFY op 2
  localparam logic [26:0] CORR_B = 27'h0A0404C;  // MIX op 1 read

  logic clk, rstn, start, start_w;
  logic wr_fin, rd_fin;
  logic [31:0] rd_data;
  logic [26:0] rd_addr, wr_addr, first_err_addr;
  logic [31:0] wr_data;
  logic rd_en, wr_en, busy, done, timeout;
  logic [15:0] err_cnt;

  logic wr_fin_w, rd_fin_w;
  logic [31:0] rd_data_w;
  logic [26:0] rd_addr_w, wr_addr_w, first_err_addr_w;
  logic [31:0] wr_data_w;
  logic rd_en_w, wr_en_w, busy_w, done_w, timeout_w;
  logic [15:0] err_cnt_w;

  logic auto, man_wr, man_rd, corr_a_on, corr_b_on;
  logic [2:0] wsr, rsr, wsr_w, rsr_w;
  logic [31:0] rq0, rq1, rq2, rqw0, rqw1, rqw2;
  logic [31:0] mem [logic [27:0]];

  int vectors = 0;
  int miscompares = 0;

  cache_traffic_checker #(
    .ADDR_W(27), .DATA_W(32), .N_OPS(4), .BASE(27'd0), .STRIDE(STR),
    .MIX_STRIDE(MSTR), .SEED(32'd1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cache2core_wr_fin(wr_fin), .cache2core_rd_fin(rd_fin), .cache2core_rd_data(rd_data),
    .core2cache_rd_addr(rd_addr), .core2cache_wr_addr(wr_addr), .core2cache_wr_data(wr_data),
    .core2cache_rd_en(rd_en), .core2cache_wr_en(wr_en), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .timeout(timeout)
  );

  cache_traffic_checker #(
    .ADDR_W(27), .DATA_W(32), .N_OPS(4), .BASE(WBASE), .STRIDE(27'd16),
    .MIX_STRIDE(MSTR), .SEED(32'd1), .TIMEOUT(8)
  ) dut_w (
    .clk(clk), .rstn(rstn), .start(start_w),
    .cache2core_wr_fin(wr_fin_w), .cache2core_rd_fin(rd_fin_w), .cache2core_rd_data(rd_data_w),
    .core2cache_rd_addr(rd_addr_w), .core2cache_wr_addr(wr_addr_w), .core2cache_wr_data(wr_data_w),
    .core2cache_rd_en(rd_en_w), .core2cache_wr_en(wr_en_w), .busy(busy_w), .done(done_w),
    .err_cnt(err_cnt_w), .first_err_addr(first_err_addr_w), .timeout(timeout_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_lookup(input logic sel, input logic [26:0] a);
    logic [31:0] v;
    v = mem.exists({sel, a}) ? mem[{sel, a}] : 32'h0;
    if (!sel && ((corr_a_on && a == CORR_A) || (corr_b_on && a == CORR_B))) v = v ^ 32'h1;
    return v;
  endfunction

  // Memory model: fin and read data three cycles after the en pulse.
  always @(posedge clk) begin
    if (!rstn) begin
      wsr <= '0; rsr <= '0; wsr_w <= '0; rsr_w <= '0;
    end else begin
      wsr   <= {wsr[1:0], wr_en};
      rsr   <= {rsr[1:0], rd_en};
      wsr_w <= {wsr_w[1:0], wr_en_w};
      rsr_w <= {rsr_w[1:0], rd_en_w};
      if (wr_en)   mem[{1'b0, wr_addr}]   = wr_data;
      if (wr_en_w) mem[{1'b1, wr_addr_w}] = wr_data_w;
      rq0  <= rd_lookup(1'b0, rd_addr);
      rq1  <= rq0;
      rq2  <= rq1;
      rqw0 <= rd_lookup(1'b1, rd_addr_w);
      rqw1 <= rqw0;
      rqw2 <= rqw1;
    end
  end

  assign wr_fin    = (wsr[2] & auto) | man_wr;
  assign rd_fin    = (rsr[2] & auto) | man_rd;
  assign rd_data   = rq2;
  assign wr_fin_w  = wsr_w[2];
  assign rd_fin_w  = rsr_w[2];
  assign rd_data_w = rqw2;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_en(input bit w, output int waited);
    waited = 0;
    do begin tick(1); waited++; end
    while (!(w ? (wr_en_w | rd_en_w) : (wr_en | rd_en)) && waited < 60);
  endtask

  task automatic wait_done(input bit w, output int waited);
    waited = 0;
    while (!(w ? done_w : done) && waited < 400) begin tick(1); waited++; end
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if ({rd_addr, wr_addr, wr_data, rd_en, wr_en, busy, done, err_cnt, first_err_addr, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%h wa=%h want all zero", busy, done, err_cnt, wr_addr);
    end
    vectors++;
    if ({rd_addr_w, wr_addr_w, wr_data_w, rd_en_w, wr_en_w, busy_w, done_w, err_cnt_w, timeout_w} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs_w: got busy=%b wa=%h want all zero", busy_w, wr_addr_w);
    end
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_fill_verify_mix();
    int waited, j;
    logic is_wr;
    logic [26:0] ea;
    logic [31:0] ed;
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL main_busy: got %b want 1", busy); end
    for (int k = 0; k < 16; k++) begin
      wait_en(0, waited);
      if (k < 4) begin
        is_wr = 1'b1; ea = 27'(k * 32'h0214C0C); ed = 32'(k + 1);
      end else if (k < 8) begin
        is_wr = 1'b0; ea = 27'((k - 4) * 32'h0214C0C); ed = 32'h0;
      end else begin
        j = (k - 8) / 2;
        is_wr = ((k % 2) == 0); ea = 27'(j * 32'h0A0404C); ed = ~32'(j + 1);
      end
      vectors++;
      if (waited !== ((k == 0) ? 1 : 5)) begin
        miscompares++; $display("FAIL main_period op%0d: got %0d cycles want %0d", k, waited, (k == 0) ? 1 : 5);
      end
      vectors++;
      if ({wr_en, rd_en} !== {is_wr, ~is_wr}) begin
        miscompares++; $display("FAIL main_optype op%0d: got wr=%b rd=%b want wr=%b", k, wr_en, rd_en, is_wr);
      end
      vectors++;
      if ((is_wr ? wr_addr : rd_addr) !== ea) begin
        miscompares++; $display("FAIL main_addr op%0d: got %h want %h", k, is_wr ? wr_addr : rd_addr, ea);
      end
      if (is_wr) begin
        vectors++;
        if (wr_data !== ed) begin
          miscompares++; $display("FAIL main_data op%0d: got %h want %h", k, wr_data, ed);
        end
      end
    end
    tick(3);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL main_done_early: got %b want 0", done); end
    tick(1);
    vectors++;
    if ({done, busy, err_cnt, timeout} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      miscompares++; $display("FAIL main_end: got done=%b busy=%b err=%h to=%b want 1 0 0000 0", done, busy, err_cnt, timeout);
    end
  endtask

  task automatic test_ignored_fins();
    int waited;
    logic any_en;
    auto = 1'b0;
    pulse_start();
    wait_en(0, waited);
    vectors++;
    if ({wr_en, wr_addr} !== {1'b1, 27'h0}) begin
      miscompares++; $display("FAIL ign_op0: got wr_en=%b addr=%h want 1 0", wr_en, wr_addr);
    end
    man_wr = 1'b1; man_rd = 1'b1;
    any_en = 1'b0;
    tick(1); man_wr = 1'b0; start = 1'b1; any_en |= wr_en | rd_en;
    tick(1); start = 1'b0; any_en |= wr_en | rd_en;
    tick(1); any_en |= wr_en | rd_en;
    vectors++;
    if ({any_en, busy} !== 2'b01) begin
      miscompares++; $display("FAIL ign_stray: got any_en=%b busy=%b want 0 1", any_en, busy);
    end
    man_rd = 1'b0; man_wr = 1'b1;
    tick(1); man_wr = 1'b0;
    vectors++;
    if (wr_en !== 1'b0) begin miscompares++; $display("FAIL ign_gap: got wr_en=%b want 0", wr_en); end
    tick(1);
    vectors++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, STR, 32'd2}) begin
      miscompares++; $display("FAIL ign_op1: got en=%b addr=%h data=%h want 1 %h 2", wr_en, wr_addr, wr_data, STR);
    end
    auto = 1'b1;
    for (int n = 2; n <= 5; n++) wait_en(0, waited);
    vectors++;
    if ({rd_en, rd_addr} !== {1'b1, STR}) begin
      miscompares++; $display("FAIL ign_op5: got rd_en=%b addr=%h want 1 %h", rd_en, rd_addr, STR);
    end
    rstn = 1'b0;
    tick(1);
    vectors++;
    if ({rd_addr, wr_addr, wr_data, rd_en, wr_en, busy, done, err_cnt, first_err_addr, timeout} !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got busy=%b ra=%h wa=%h want all zero", busy, rd_addr, wr_addr);
    end
    tick(1);
    rstn = 1'b1;
    tick(1);
    pulse_start();
    wait_en(0, waited);
    vectors++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 27'h0, 32'd1}) begin
      miscompares++; $display("FAIL rerun_op0: got en=%b addr=%h data=%h want 1 0 1", wr_en, wr_addr, wr_data);
    end
    wait_done(0, waited);
    vectors++;
    if ({done, err_cnt} !== {1'b1, 16'h0}) begin
      miscompares++; $display("FAIL rerun_done: got done=%b err=%h want 1 0000", done, err_cnt);
    end
  endtask

  task automatic test_errors();
    int waited;
    corr_a_on = 1'b1; corr_b_on = 1'b1;
    pulse_start();
    for (int n = 0; n < 7; n++) wait_en(0, waited);
    tick(3);
    vectors++;
    if (err_cnt !== 16'h0) begin miscompares++; $display("FAIL err_early: got %h want 0000", err_cnt); end
    tick(1);
    vectors++;
    if ({err_cnt, first_err_addr} !== {16'h1, CORR_A}) begin
      miscompares++; $display("FAIL err_first: got cnt=%h addr=%h want 0001 %h", err_cnt, first_err_addr, CORR_A);
    end
    wait_done(0, waited);
    vectors++;
    if ({done, err_cnt, first_err_addr, timeout} !== {1'b1, 16'h2, CORR_A, 1'b0}) begin
      miscompares++; $display("FAIL err_second: got done=%b cnt=%h addr=%h to=%b want 1 0002 %h 0", done, err_cnt, first_err_addr, timeout, CORR_A);
    end
    corr_a_on = 1'b0; corr_b_on = 1'b0;
  endtask

  task automatic test_timeout();
    int waited, extra;
    auto = 1'b0;
    pulse_start();
    vectors++;
    if ({err_cnt, first_err_addr, done} !== '0) begin
      miscompares++; $display("FAIL restart_clear_err: got cnt=%h addr=%h done=%b want 0 0 0", err_cnt, first_err_addr, done);
    end
    wait_en(0, waited);
    extra = 0;
    for (int n = 0; n < 7; n++) begin tick(1); extra += int'(wr_en | rd_en); end
    vectors++;
    if ({done, timeout} !== 2'b00) begin
      miscompares++; $display("FAIL to_early: got done=%b to=%b want 0 0", done, timeout);
    end
    tick(1); extra += int'(wr_en | rd_en);
    vectors++;
    if ({done, timeout, busy, err_cnt} !== {1'b1, 1'b1, 1'b0, 16'h0} || extra != 0) begin
      miscompares++; $display("FAIL to_expire: got done=%b to=%b busy=%b err=%h extra_en=%0d want 1 1 0 0000 0", done, timeout, busy, err_cnt, extra);
    end
  endtask

  task automatic test_restart();
    int waited;
    auto = 1'b1;
    pulse_start();
    vectors++;
    if ({timeout, done, busy} !== 3'b001) begin
      miscompares++; $display("FAIL restart_clear_to: got to=%b done=%b busy=%b want 0 0 1", timeout, done, busy);
    end
    wait_done(0, waited);
    vectors++;
    if ({done, err_cnt, timeout} !== {1'b1, 16'h0, 1'b0}) begin
      miscompares++; $display("FAIL restart_run: got done=%b err=%h to=%b want 1 0000 0", done, err_cnt, timeout);
    end
  endtask

  task automatic test_wrap();
    int waited;
    start_w = 1'b1; tick(1); start_w = 1'b0;
    wait_en(1, waited);
    vectors++;
    if ({wr_en_w, wr_addr_w} !== {1'b1, WBASE}) begin
      miscompares++; $display("FAIL wrap_op0: got en=%b addr=%h want 1 %h", wr_en_w, wr_addr_w, WBASE);
    end
    wait_en(1, waited);
    vectors++;
    if ({wr_en_w, wr_addr_w} !== {1'b1, 27'h0}) begin
      miscompares++; $display("FAIL wrap_op1: got en=%b addr=%h want 1 0000000", wr_en_w, wr_addr_w);
    end
    wait_done(1, waited);
    vectors++;
    if ({done_w, err_cnt_w, timeout_w} !== {1'b1, 16'h0, 1'b0}) begin
      miscompares++; $display("FAIL wrap_run: got done=%b err=%h to=%b want 1 0000 0", done_w, err_cnt_w, timeout_w);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; start_w = 1'b0;
    auto = 1'b1; man_wr = 1'b0; man_rd = 1'b0;
    corr_a_on = 1'b0; corr_b_on = 1'b0;
    test_reset();
    test_fill_verify_mix();
    test_ignored_fins();
    test_errors();
    test_timeout();
    test_restart();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_traffic_checker.md
# cache_traffic_checker

Parametrised self-checking traffic generator for the data cache. It sits in the core's place on the core-to-cache port and runs three phases: fill writes, verify reads, then interleaved write/read-back. Every read is compared against the expected value, and errors, the first failing address and handshake timeouts are reported. It is used for on-board bring-up and for cache regression benches.

## Interface
- `ADDR_W`, 27: cache address width.
- `DATA_W`, 32: data word width.
- `N_OPS`, 100: operations per phase; must be ≥1 and < 2^16.
- `BASE`, 0: first address of every phase.
- `STRIDE`, 27'h0214C0C: address increment for FILL and VERIFY, taken modulo 2^ADDR_W.
- `MIX_STRIDE`, 27'h0A0404C: address increment for MIX, taken modulo 2^ADDR_W.
- `SEED`, 32'd1: data of FILL op 0.
- `TIMEOUT`, 1023: maximum cycles to wait for a fin; must be ≥1.
- `clk` in 1: single clock.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a run.
- `cache2core_wr_fin` in 1: cache has completed the outstanding write.
- `cache2core_rd_fin` in 1: cache has completed the outstanding read; `cache2core_rd_data` is valid in this cycle.
- `cache2core_rd_data` in DATA_W: read data.
- `core2cache_rd_addr` out ADDR_W; `core2cache_wr_addr` out ADDR_W; `core2cache_wr_data` out DATA_W.
- `core2cache_rd_en` out 1; `core2cache_wr_en` out 1: one-cycle request pulses.
- `busy` out 1; `done` out 1: done stays high until the next start.
- `err_cnt` out 16: count of read mismatches; saturates at 16'hFFFF.
- `first_err_addr` out ADDR_W: address of the first mismatch.
- `timeout` out 1: sticky flag, set when a fin did not arrive in time.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- Phases: FILL, VERIFY, MIX. Each phase has an op index i = 0..N_OPS-1. MIX runs 2·N_OPS ops.
- FILL: write addr = BASE + i·STRIDE, data = SEED + i (modulo 2^DATA_W).
- VERIFY: read the same addresses; expected data = SEED + i.
- MIX: for each i, write addr = BASE + i·MIX_STRIDE with data ~(SEED + i), then read the same address. Expected data = ~(SEED + i).
- Addresses are generated by a running accumulator. No multiplier is used. Wrap-around modulo 2^ADDR_W is legal.
- Mismatch: `err_cnt` increments (saturating). On the first mismatch of a run, `first_err_addr` latches the read address.
- IDLE/DONE + start → ISSUE. This clears `err_cnt`, `first_err_addr`, `timeout` and `done`, and resets the phase and index to FILL/0.
- start during ISSUE or WAIT is ignored.
- ISSUE → WAIT always.
- WAIT + matching fin → ISSUE for the next op. After the last MIX op completes, the FSM goes to DONE instead.
- WAIT with no fin for TIMEOUT cycles → DONE with `timeout` = 1. The outstanding op is abandoned.
- Only the fin that matches the outstanding op type counts. The other fin, and any fin seen in IDLE, ISSUE or DONE, is ignored.
- Simultaneous `wr_fin` and `rd_fin`: only the matching one is used.
- Reset values: all outputs are 0, the addresses are 0 and the state is IDLE.
- Reset mid-run abandons the outstanding op. The cache must be reset together with this block.

## Timing
- All outputs are registered.
- An en pulse is high for exactly one cycle, C0. Address and data are valid at C0 and held stable until the matching fin.
- fin is sampled from C0+1 onward; a fin at C0 is ignored.
- If fin is high in cycle Cf, the next en is high at Cf+2. This gives one idle cycle between ops, and an op period of L+2 cycles for fin latency L.
- Read data is compared in cycle Cf. `err_cnt` and `first_err_addr` update in Cf+1.
- `done` rises the cycle after the last fin or after the timeout expires.
- `busy` = state ∈ {ISSUE, WAIT}.
- Timeout counter: it is cleared in ISSUE. `timeout` is set at the end of the TIMEOUT-th consecutive WAIT cycle without a matching fin.

## Structure
- Package `cache_dbg_pkg` holds the state and phase enums, the default `ADDR_W`/`DATA_W`, and the `ERR_CNT_W` = 16 constant.
- Sub-module `cache_dbg_addr_gen` is the stride accumulator. Its inputs are clear-to-BASE, step and a stride select; its output is the current address.
- The write path and the read path each have their own address register, as seen by the cache.

## Test plan
- Ideal memory, L = 3, N_OPS = 4, start → 16 ops at a period of 5 cycles; `done` = 1, `err_cnt` = 0, `timeout` = 0.
- Memory that returns SEED+2 XOR 1 on VERIFY op 2 → `err_cnt` = 1 and `first_err_addr` = BASE + 2·STRIDE. A further error in MIX → `err_cnt` = 2 and `first_err_addr` is unchanged.
- `wr_fin` never asserted, TIMEOUT = 8 → exactly one `wr_en` pulse; `done` and `timeout` are 1 eight cycles after WAIT is entered; `err_cnt` = 0.
- BASE = 2^27−16, STRIDE = 16 → the op 1 address is 0 and the run passes.
- A stray `rd_fin` during a write WAIT, and a fin at C0, are ignored. A second start mid-run is ignored. Reset at op 5 gives all outputs 0; a new start reruns FILL from op 0.
- Restart after DONE with errors present → `err_cnt` and `timeout` are cleared in the cycle after start.
